// File: rtl/dmtd_meter.sv
// DMTD beat-signal meter: deglitches the phase-detector XOR output and reports
// per-period high time and period length over a valid/ready stream.
module dmtd_meter #(
    parameter int CNT_W    = 16,
    parameter int DEGLITCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dmtd_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_sat,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int                RUN_W    = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(DEGLITCH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    // Saturating increment; MSB of the result flags an attempted overflow.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] x);
        if (x == CNT_MAX)
            return {1'b1, x};
        else
            return {1'b0, x + CNT_ONE};
    endfunction

    logic             filt, filt_d;
    logic [RUN_W-1:0] run;
    logic             rise, fall;
    state_t           state, state_nx;
    logic             load, inc_hc, inc_pc, publish, clear;
    logic [CNT_W-1:0] hc, pc;
    logic             sat_acc;
    logic [CNT_W:0]   hc_inc, pc_inc;

    // Stage p0: glitch filter, free-running so edges are clean before en rises
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b0;
            filt_d <= 1'b0;
            run    <= '0;
        end else begin
            filt_d <= filt;
            if (dmtd_in != filt) begin
                if (run == RUN_LAST) begin
                    filt <= ~filt;
                    run  <= '0;
                end else begin
                    run <= run + RUN_W'(1);
                end
            end else begin
                run <= '0;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARM;
                ARM:     if (rise) state_nx = HIGH;
                HIGH:    if (fall) state_nx = LOW;
                LOW:     if (rise) state_nx = HIGH;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        load    = 1'b0;
        inc_hc  = 1'b0;
        inc_pc  = 1'b0;
        publish = 1'b0;
        clear   = !en || (state == IDLE);
        if (en) begin
            case (state)
                ARM:  load = rise;
                HIGH: begin
                    inc_pc = 1'b1;
                    inc_hc = !fall;
                end
                LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                        load    = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hc_inc = sat_inc(hc);
    assign pc_inc = sat_inc(pc);

    // Stage p1: high/period counters with sticky per-period saturation flag
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hc      <= '0;
            pc      <= '0;
            sat_acc <= 1'b0;
        end else if (load) begin
            hc      <= CNT_ONE;
            pc      <= CNT_ONE;
            sat_acc <= 1'b0;
        end else begin
            if (inc_hc) hc <= hc_inc[CNT_W-1:0];
            if (inc_pc) pc <= pc_inc[CNT_W-1:0];
            sat_acc <= sat_acc | (inc_hc & hc_inc[CNT_W]) | (inc_pc & pc_inc[CNT_W]);
        end
    end

    // Stage p2: result holding register; a result arriving while stalled is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid  <= 1'b0;
            meas_high   <= '0;
            meas_period <= '0;
            meas_sat    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (publish && (!meas_valid || meas_ready)) begin
                meas_valid  <= 1'b1;
                meas_high   <= hc;
                meas_period <= pc;
                meas_sat    <= sat_acc;
            end else if (meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (publish && meas_valid && !meas_ready)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmtd_meter.sv
// Scoreboard bench for dmtd_meter (CNT_W=8, DEGLITCH=4): directed beat waveforms,
// expected results queued by the stimulus and checked by a decoupled monitor.
module tb_dmtd_meter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, en, dmtd_in, meas_ready, clr_overrun;
    logic             meas_valid, meas_sat, overrun;
    logic [CNT_W-1:0] meas_high, meas_period;

    logic [2*CNT_W:0] exp_q[$];
    logic [2*CNT_W:0] held;
    logic             stall_prev = 1'b0;
    int               n_chk = 0;
    int               n_pass = 0;
    int               n_res = 0;
    int               res_before;

    dmtd_meter #(.CNT_W(CNT_W), .DEGLITCH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dmtd_in    (dmtd_in),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_high  (meas_high),
        .meas_period(meas_period),
        .meas_sat   (meas_sat),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2*CNT_W:0] res(input int h, input int p, input bit s);
        return {CNT_W'(h), CNT_W'(p), s};
    endfunction

    task automatic cyc(input logic d);
        dmtd_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic low(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) cyc(1'b1);
            repeat (l) cyc(1'b0);
        end
    endtask

    // Final rise closes the last full period, then measurement is disabled.
    task automatic close_and_stop();
        repeat (10) cyc(1'b1);
        en = 1'b0;
        low(20);
    endtask

    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            chk("high_le_period", 32'(meas_high <= meas_period), 32'd1);
            if (meas_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got h=%0d p=%0d s=%0b required none at %0t",
                             meas_high, meas_period, meas_sat, $time);
                end else begin
                    chk("result", 32'({meas_high, meas_period, meas_sat}), 32'(exp_q.pop_front()));
                end
                n_res++;
            end else begin
                if (stall_prev) chk("hold_stable", 32'({meas_high, meas_period, meas_sat}), 32'(held));
                held       = {meas_high, meas_period, meas_sat};
                stall_prev = 1'b1;
            end
        end
        if (rst || !(meas_valid && !meas_ready)) stall_prev = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; dmtd_in = 1'b0; meas_ready = 1'b1; clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data", 32'({meas_high, meas_period, meas_sat}), 32'd0);
        rst = 1'b0;

        // Glitch rejection: a 3-cycle pulse never passes the filter
        res_before = n_res;
        en = 1'b1;
        low(20);
        repeat (3) cyc(1'b1);
        low(60);
        chk("glitch_no_result", 32'(n_res - res_before), 32'd0);
        chk("glitch_valid", 32'(meas_valid), 32'd0);
        en = 1'b0;
        low(5);

        // Plain square wave 10/30, always ready
        exp_q.push_back(res(10, 40, 0));
        exp_q.push_back(res(10, 40, 0));
        exp_q.push_back(res(10, 40, 0));
        en = 1'b1;
        low(20);
        wave(10, 30, 3);
        close_and_stop();
        chk("square_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("square_overrun", 32'(overrun), 32'd0);

        // Backpressure: first result held, later ones dropped
        meas_ready = 1'b0;
        exp_q.push_back(res(10, 40, 0));
        en = 1'b1;
        low(20);
        wave(10, 30, 3);
        close_and_stop();
        chk("bp_valid_held", 32'(meas_valid), 32'd1);
        chk("bp_overrun_set", 32'(overrun), 32'd1);
        chk("bp_held_data", 32'({meas_high, meas_period, meas_sat}), 32'(res(10, 40, 0)));
        meas_ready = 1'b1;
        low(1);
        meas_ready = 1'b0;
        low(2);
        chk("bp_valid_dropped", 32'(meas_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        low(1);
        clr_overrun = 1'b0;
        chk("bp_overrun_cleared", 32'(overrun), 32'd0);
        meas_ready = 1'b1;

        // Saturation of both counters, then a normal period
        exp_q.push_back(res(255, 255, 1));
        exp_q.push_back(res(10, 40, 0));
        en = 1'b1;
        low(20);
        wave(300, 20, 1);
        wave(10, 30, 1);
        close_and_stop();
        chk("sat_queue_empty", 32'(exp_q.size()), 32'd0);

        // en dropped 5 cycles into a high phase, re-enabled 50 cycles later
        exp_q.push_back(res(10, 40, 0));
        exp_q.push_back(res(10, 40, 0));
        en = 1'b1;
        low(20);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) en = 1'b0;
            cyc(1'b1);
        end
        low(30);
        repeat (10) cyc(1'b1);
        low(5);
        en = 1'b1;
        low(25);
        wave(10, 30, 2);
        close_and_stop();
        chk("endrop_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a result is pending and overrun is set
        meas_ready = 1'b0;
        en = 1'b1;
        low(20);
        wave(10, 30, 2);
        repeat (10) cyc(1'b1);
        low(10);
        chk("pre_rst_valid", 32'(meas_valid), 32'd1);
        chk("pre_rst_overrun", 32'(overrun), 32'd1);
        rst = 1'b1;
        low(1);
        rst = 1'b0;
        chk("post_rst_valid", 32'(meas_valid), 32'd0);
        chk("post_rst_overrun", 32'(overrun), 32'd0);
        chk("post_rst_data", 32'({meas_high, meas_period, meas_sat}), 32'd0);
        meas_ready = 1'b1;
        exp_q.push_back(res(10, 40, 0));
        exp_q.push_back(res(10, 40, 0));
        low(20);
        wave(10, 30, 2);
        close_and_stop();
        chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmtd_meter.md
Name: dmtd_meter

Overview:
- Consumer of the DMTD beat signal: takes the already-synchronised XOR output of the dual-mixer phase detector and measures it.
- Per beat period it produces the high time (phase-difference numerator) and the full period (denominator) in clk cycles.
- Results are delivered over a valid/ready stream to the phase-tracking logic downstream.
- Includes a glitch filter for edge jitter near zero crossings, counter saturation, and overrun reporting.

Parameters:
- CNT_W, 16, width of the high/period counters and results.
- DEGLITCH, 4, consecutive agreeing samples required to accept a level change (>=1; 1 = no filtering).

Ports:
- clk  in  1  system clock; dmtd_in is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- en  in  1  measurement enable.
- dmtd_in  in  1  beat signal (phase-detector output, already synchronised).
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts the result.
- meas_high  out  CNT_W  clk cycles the filtered beat was high in the period.
- meas_period  out  CNT_W  clk cycles between consecutive filtered rising edges.
- meas_sat  out  1  either counter saturated during this period.
- overrun  out  1  sticky: a result was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0: meas_valid, meas_high, meas_period, meas_sat, overrun.
  - Filter state goes to 0, FSM goes to IDLE, counters clear.
  - Reset mid-measurement discards everything, including a pending unaccepted result.
- Glitch filter (runs regardless of en):
  - filt is the registered filtered level; a run counter counts consecutive samples with dmtd_in != filt.
  - Any sample equal to filt zeroes the run counter.
  - filt toggles on the edge that samples the DEGLITCH-th consecutive differing value.
  - rise/fall events are filt vs. its 1-cycle delayed copy, so both edges see identical delay and widths are preserved.
- FSM states:
  - IDLE: counters held at 0. If en=1, go to ARM.
  - ARM: wait for the first rise event; any partial period is discarded. On rise, load hc=1, pc=1 and go to HIGH.
  - HIGH: pc+1 and hc+1 per cycle. On fall: pc+1 only, go to LOW.
  - LOW: pc+1 per cycle. On rise: publish {hc, pc, sat}, reload hc=1, pc=1, clear sat, go to HIGH.
  - en=0 in any state goes to IDLE on the next edge; no partial result is published.
- Latency: meas_valid rises DEGLITCH+1 clk edges after the first edge that samples dmtd_in=1 (for the period-closing rise).
- Arithmetic:
  - hc and pc saturate at 2^CNT_W-1 and never wrap.
  - The sat flag sets when either counter would exceed that value.
  - Invariant: meas_high <= meas_period.
- Handshake:
  - The transfer occurs on a cycle with meas_valid=1 and meas_ready=1.
  - While meas_valid=1 and meas_ready=0, meas_high, meas_period and meas_sat hold stable.
  - meas_valid drops after a transfer unless a new result publishes in that same cycle. In that case the new data loads and meas_valid stays 1.
- Overrun:
  - Publish while meas_valid=1 and meas_ready=0: the new result is dropped, held data is kept, and overrun is set.
  - overrun clears only via clr_overrun or rst. If set and clear coincide, set wins.
- Boundary cases:
  - If filt=1 when en rises, wait in ARM for the next rise.
  - Aperiodic input (no edges) produces no results; counters simply saturate.

Test Plan:
- Glitch reject (DEGLITCH=4): dmtd_in pulses high for 3 cycles amid a low input -> filt never toggles, meas_valid stays 0, no result.
- Square wave, 10 high / 30 low, en=1, meas_ready=1 -> first result after the second rise: meas_high=10, meas_period=40, meas_sat=0; valid for exactly 1 cycle per period.
- Backpressure, meas_ready=0 for 3 periods of the same wave:
  - First result stays valid and stable; overrun=1.
  - Raise ready -> one transfer of {10,40}.
  - Pulse clr_overrun -> overrun=0.
- Saturation, CNT_W=8, 300 high / 20 low -> meas_high=255, meas_period=255, meas_sat=1; the next normal period (10/30) gives {10,40,0}.
- en drop at cycle 5 of a high phase, re-enable 50 cycles later -> no result from the partial period; first result appears after two further rises and is correct.
- Reset: rst=1 for 1 cycle while meas_valid=1 and overrun=1 -> next edge has all outputs 0; measurement restarts from ARM.
